// File: rtl/coin_acceptor_pkg.sv
// coin_pkg: coin denominations, credit values and acceptor state encoding.
package coin_pkg;

    localparam int CREDIT_UNIT_CENTS = 5;

    typedef enum logic [1:0] {
        COIN_5C  = 2'b00,
        COIN_10C = 2'b01,
        COIN_25C = 2'b10,
        COIN_50C = 2'b11
    } coin_code_t;

    localparam logic [3:0] COIN_VALUE_5C  = 4'd1;
    localparam logic [3:0] COIN_VALUE_10C = 4'd2;
    localparam logic [3:0] COIN_VALUE_25C = 4'd5;
    localparam logic [3:0] COIN_VALUE_50C = 4'd10;

    typedef enum logic [3:0] {
        S_IDLE    = 4'b0001,
        S_COLLECT = 4'b0010,
        S_VEND    = 4'b0100,
        S_REFUND  = 4'b1000
    } state_t;

    function automatic logic [3:0] coin_value(input logic [1:0] code);
        return code == COIN_5C  ? COIN_VALUE_5C  :
               code == COIN_10C ? COIN_VALUE_10C :
               code == COIN_25C ? COIN_VALUE_25C : COIN_VALUE_50C;
    endfunction

endpackage

// File: rtl/coin_timeout_timer.sv
// coin_timeout_timer: idle counter that flags expiry after TIMEOUT_CYCLES enabled cycles without clear.
module coin_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clear,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT_CYCLES);

    logic [W-1:0] count;

    assign expire = en && count == W'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (en && !expire)
            count <= count + W'(1);
    end

endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: validates coins, accumulates credit, pays the fare to the turnstile and refunds change.
// Idle refund timer is built only when COIN_ACCEPTOR_TIMEOUT_EN is defined.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int CREDIT_W       = 8,
    parameter int FARE           = 10,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid_i,
    input  logic [1:0]          coin_code_i,
    input  logic                cancel_i,
    input  logic                locked_i,
    input  logic                change_ready_i,
    output logic                coin_o,
    output logic                reject_o,
    output logic                change_valid_o,
    output logic [CREDIT_W-1:0] change_o,
    output logic [CREDIT_W-1:0] credit_o
);

    localparam logic [CREDIT_W-1:0] FARE_C = CREDIT_W'(FARE);

    if (FARE < 1 || FARE > 2**CREDIT_W - 1 || TIMEOUT_CYCLES < 2) begin : g_cfg_err
        $error("coin_acceptor: illegal FARE/TIMEOUT_CYCLES configuration");
    end

    state_t              state, state_n;
    logic [CREDIT_W-1:0] credit, credit_n, value;
    logic [CREDIT_W:0]   sum;
    logic                fits, coin_n, reject_n, expire;

    assign value    = CREDIT_W'(coin_value(coin_code_i));
    assign sum      = {1'b0, credit} + {1'b0, value};
    assign fits     = !sum[CREDIT_W];
    assign credit_o = credit;

`ifdef COIN_ACCEPTOR_TIMEOUT_EN
    coin_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (state == S_COLLECT),
        .clear  (coin_valid_i || state != S_COLLECT),
        .expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        credit_n = credit;
        coin_n   = 1'b0;
        reject_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (coin_valid_i) begin
                    if (fits) begin
                        credit_n = sum[CREDIT_W-1:0];
                        state_n  = credit_n >= FARE_C ? S_VEND : S_COLLECT;
                    end else
                        reject_n = 1'b1;
                end
            end
            S_COLLECT: begin
                // a coin landing with cancel is credited before the refund amount is taken
                if (coin_valid_i) begin
                    if (fits)
                        credit_n = sum[CREDIT_W-1:0];
                    else
                        reject_n = 1'b1;
                end
                if (cancel_i)
                    state_n = S_REFUND;
                else if (credit_n >= FARE_C)
                    state_n = S_VEND;
                else if (expire && !coin_valid_i)
                    state_n = S_REFUND;
            end
            S_VEND: begin
                reject_n = coin_valid_i;
                if (locked_i) begin
                    coin_n   = 1'b1;
                    credit_n = credit - FARE_C;
                    state_n  = credit_n != '0 ? S_REFUND : S_IDLE;
                end
            end
            S_REFUND: begin
                reject_n = coin_valid_i;
                if (change_ready_i) begin
                    credit_n = '0;
                    state_n  = S_IDLE;
                end
            end
            default: begin
                state_n  = S_IDLE;
                credit_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            credit         <= '0;
            coin_o         <= 1'b0;
            reject_o       <= 1'b0;
            change_valid_o <= 1'b0;
            change_o       <= '0;
        end else begin
            state          <= state_n;
            credit         <= credit_n;
            coin_o         <= coin_n;
            reject_o       <= reject_n;
            change_valid_o <= state_n == S_REFUND;
            change_o       <= state_n == S_REFUND ? credit_n : '0;
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: directed checks of fare payment, change, cancel, timeout, blocked vend and reset.
module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_code = 2'b00;
    logic       cancel = 1'b0;
    logic       locked = 1'b0;
    logic       change_ready = 1'b0;
    logic       coin_o, reject_o, change_valid_o;
    logic [7:0] change_o, credit_o;

    int checks = 0;
    int errors = 0;

    coin_acceptor #(.CREDIT_W(8), .FARE(10), .TIMEOUT_CYCLES(20)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .coin_valid_i   (coin_valid),
        .coin_code_i    (coin_code),
        .cancel_i       (cancel),
        .locked_i       (locked),
        .change_ready_i (change_ready),
        .coin_o         (coin_o),
        .reject_o       (reject_o),
        .change_valid_o (change_valid_o),
        .change_o       (change_o),
        .credit_o       (credit_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] code);
        coin_valid = 1'b1;
        coin_code  = code;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic outs(input string tag, input logic c, input logic r, input logic v,
                        input logic [7:0] chg, input logic [7:0] cr);
        chk({tag, ".coin"}, coin_o, c);
        chk({tag, ".reject"}, reject_o, r);
        chk({tag, ".cvalid"}, change_valid_o, v);
        chk({tag, ".change"}, change_o, chg);
        chk({tag, ".credit"}, credit_o, cr);
    endtask

    initial begin
        #2;
        outs("reset", 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // exact fare
        locked = 1'b1;
        coin(2'b10);
        outs("t1.c1", 0, 0, 0, 0, 5);
        coin(2'b10);
        outs("t1.c2", 0, 0, 0, 0, 10);
        tick();
        outs("t1.vend", 1, 0, 0, 0, 0);
        tick();
        outs("t1.idle", 0, 0, 0, 0, 0);

        // overpay, change held until ready
        coin(2'b10);
        coin(2'b11);
        outs("t2.fare", 0, 0, 0, 0, 15);
        tick();
        outs("t2.vend", 1, 0, 1, 5, 5);
        for (int i = 0; i < 3; i++) begin
            tick();
            outs("t2.hold", 0, 0, 1, 5, 5);
        end
        change_ready = 1'b1;
        tick();
        change_ready = 1'b0;
        outs("t2.done", 0, 0, 0, 0, 0);

        // cancel, then coin and cancel in the same cycle
        coin(2'b01);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        outs("t3.cancel", 0, 0, 1, 2, 2);
        change_ready = 1'b1;
        tick();
        change_ready = 1'b0;
        outs("t3.done", 0, 0, 0, 0, 0);
        coin(2'b01);
        cancel = 1'b1;
        coin(2'b00);
        cancel = 1'b0;
        outs("t3.both", 0, 0, 1, 3, 3);
        change_ready = 1'b1;
        tick();
        change_ready = 1'b0;
        outs("t3.done2", 0, 0, 0, 0, 0);

        // idle timeout
        coin(2'b00);
        repeat (19) tick();
        outs("t4.wait", 0, 0, 0, 0, 1);
        tick();
`ifdef COIN_ACCEPTOR_TIMEOUT_EN
        outs("t4.timeout", 0, 0, 1, 1, 1);
`else
        outs("t4.notimeout", 0, 0, 0, 0, 1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        outs("t4.cancel", 0, 0, 1, 1, 1);
`endif
        change_ready = 1'b1;
        tick();
        change_ready = 1'b0;
        outs("t4.done", 0, 0, 0, 0, 0);

        // blocked vend
        locked = 1'b0;
        coin(2'b11);
        outs("t5.fare", 0, 0, 0, 0, 10);
        tick();
        outs("t5.blocked", 0, 0, 0, 0, 10);
        coin(2'b00);
        outs("t5.reject", 0, 1, 0, 0, 10);
        tick();
        outs("t5.after", 0, 0, 0, 0, 10);
        locked = 1'b1;
        tick();
        outs("t5.vend", 1, 0, 0, 0, 0);
        tick();
        outs("t5.idle", 0, 0, 0, 0, 0);

        // asynchronous reset while refunding
        coin(2'b01);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        outs("t6.refund", 0, 0, 1, 2, 2);
        #2 rst_n = 1'b0;
        #1;
        outs("t6.async", 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        outs("t6.released", 0, 0, 0, 0, 0);
        coin(2'b10);
        outs("t6.idle", 0, 0, 0, 0, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
